kf_host_driver: RTL and testbench

KF_HOST_DRIVER -- requirements
Module: kf_host_driver

---
 rtl/kf_host_driver.sv | 201 ++++++++++++++++++++
 tb/tb_kf_host_driver.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kf_host_driver.sv
// Host-side driver for the Kalman-filter core: streams a program into the core ROM,
// then feeds measurements and returns AU results. Optional watchdog: KF_DRV_TIMEOUT_EN.
module kf_host_driver #(
  parameter int unsigned W       = 24,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_req,
  input  logic [8:0]   prog_len,
  input  logic         prog_tvalid,
  output logic         prog_tready,
  input  logic [15:0]  prog_tdata,
  input  logic         meas_tvalid,
  output logic         meas_tready,
  input  logic [W-1:0] meas_tdata,
  output logic         res_tvalid,
  input  logic         res_tready,
  output logic [W-1:0] res_tdata,
  output logic         rom_we,
  output logic [7:0]   rom_waddr,
  output logic [15:0]  rom_wdata,
  output logic         kf_start,
  output logic [W-1:0] kf_data_in,
  input  logic         kf_ready,
  input  logic [W-1:0] kf_result,
  input  logic         kf_au_done,
  output logic         loaded,
  output logic         busy,
  output logic         err
);

  localparam int unsigned CW = 9;
  localparam logic [CW-1:0] MAX_LEN = CW'(256);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, WAIT_LO, WAIT_HI} state_e;

  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("kf_host_driver: TIMEOUT must be at least 1");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] len_q, len_d;
  logic          loaded_q, loaded_d;
  logic          busy_q, busy_d;
  logic          rom_we_q, rom_we_d;
  logic [7:0]    rom_waddr_q, rom_waddr_d;
  logic [15:0]   rom_wdata_q, rom_wdata_d;
  logic          kf_start_q, kf_start_d;
  logic [W-1:0]  kf_data_q, kf_data_d;
  logic [W-1:0]  cap_q, cap_d;
  logic          res_valid_q, res_valid_d;
  logic [W-1:0]  res_data_q, res_data_d;

  logic load_go, prog_hs, meas_hs, last_word, in_wait, res_fire, tmo_hit;

  assign load_go     = load_req && (state_q == IDLE || state_q == RUN)
                       && (prog_len != '0) && (prog_len <= MAX_LEN);
  assign prog_tready = (state_q == LOAD);
  assign prog_hs     = prog_tvalid && prog_tready;
  assign last_word   = (cnt_q + CW'(1)) == len_q;
  // A pending load request takes priority over starting a new filter run.
  assign meas_tready = (state_q == RUN) && loaded_q && kf_ready && !res_valid_q && !load_go;
  assign meas_hs     = meas_tvalid && meas_tready;
  assign in_wait     = (state_q == WAIT_LO) || (state_q == WAIT_HI);
  assign res_fire    = (state_q == WAIT_HI) && kf_ready;

`ifdef KF_DRV_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  assign tmo_hit = in_wait && (tmo_q == TW'(TIMEOUT - 1));
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  // Wait-cycle counter restarts with every accepted measurement.
  always_comb begin
    tmo_d = tmo_q;
    err_d = err_q;
    if (meas_hs)      tmo_d = '0;
    else if (in_wait) tmo_d = tmo_q + TW'(1);
    if (tmo_hit && !res_fire) err_d = 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      loaded_q    <= 1'b0;
      busy_q      <= 1'b0;
      rom_we_q    <= 1'b0;
      rom_waddr_q <= '0;
      rom_wdata_q <= '0;
      kf_start_q  <= 1'b0;
      kf_data_q   <= '0;
      cap_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      loaded_q    <= loaded_d;
      busy_q      <= busy_d;
      rom_we_q    <= rom_we_d;
      rom_waddr_q <= rom_waddr_d;
      rom_wdata_q <= rom_wdata_d;
      kf_start_q  <= kf_start_d;
      kf_data_q   <= kf_data_d;
      cap_q       <= cap_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_go) state_d = LOAD;
      LOAD:    if (prog_hs && last_word) state_d = RUN;
      RUN: begin
        if (load_go)      state_d = LOAD;
        else if (meas_hs) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (tmo_hit)       state_d = RUN;
        else if (!kf_ready) state_d = WAIT_HI;
      end
      WAIT_HI: if (kf_ready || tmo_hit) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    loaded_d    = loaded_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    rom_we_d    = 1'b0;
    rom_waddr_d = rom_waddr_q;
    rom_wdata_d = rom_wdata_q;
    kf_start_d  = 1'b0;
    kf_data_d   = kf_data_q;
    cap_d       = cap_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    busy_d      = (state_d != IDLE) && (state_d != RUN);

    if (load_go) begin
      loaded_d = 1'b0;
      cnt_d    = '0;
      len_d    = prog_len;
    end
    if (prog_hs) begin
      rom_we_d    = 1'b1;
      rom_waddr_d = cnt_q[7:0];
      rom_wdata_d = prog_tdata;
      cnt_d       = cnt_q + CW'(1);
      if (last_word) loaded_d = 1'b1;
    end
    if (meas_hs) begin
      kf_data_d  = meas_tdata;
      kf_start_d = 1'b1;
      cap_d      = '0;
    end
    if (in_wait && kf_au_done) cap_d = kf_result;
    if (res_valid_q && res_tready) res_valid_d = 1'b0;
    // A done pulse coinciding with ready-rise is the freshest result.
    if (res_fire) begin
      res_valid_d = 1'b1;
      res_data_d  = kf_au_done ? kf_result : cap_q;
    end
  end

  assign loaded     = loaded_q;
  assign busy       = busy_q;
  assign rom_we     = rom_we_q;
  assign rom_waddr  = rom_waddr_q;
  assign rom_wdata  = rom_wdata_q;
  assign kf_start   = kf_start_q;
  assign kf_data_in = kf_data_q;
  assign res_tvalid = res_valid_q;
  assign res_tdata  = res_data_q;

endmodule

// File: tb/tb_kf_host_driver.sv
// Directed self-checking bench for kf_host_driver (timeout scenario follows KF_DRV_TIMEOUT_EN).
module tb_kf_host_driver;
  localparam int unsigned W   = 24;
  localparam int unsigned TMO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_req;
  logic [8:0]   prog_len;
  logic         prog_tvalid, prog_tready;
  logic [15:0]  prog_tdata;
  logic         meas_tvalid, meas_tready;
  logic [W-1:0] meas_tdata;
  logic         res_tvalid, res_tready;
  logic [W-1:0] res_tdata;
  logic         rom_we;
  logic [7:0]   rom_waddr;
  logic [15:0]  rom_wdata;
  logic         kf_start;
  logic [W-1:0] kf_data_in;
  logic         kf_ready;
  logic [W-1:0] kf_result;
  logic         kf_au_done;
  logic         loaded, busy, err;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  int res_cnt   = 0;

  kf_host_driver #(.W(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .prog_len(prog_len),
    .prog_tvalid(prog_tvalid), .prog_tready(prog_tready), .prog_tdata(prog_tdata),
    .meas_tvalid(meas_tvalid), .meas_tready(meas_tready), .meas_tdata(meas_tdata),
    .res_tvalid(res_tvalid), .res_tready(res_tready), .res_tdata(res_tdata),
    .rom_we(rom_we), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata),
    .kf_start(kf_start), .kf_data_in(kf_data_in), .kf_ready(kf_ready),
    .kf_result(kf_result), .kf_au_done(kf_au_done),
    .loaded(loaded), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (kf_start === 1'b1) start_cnt++;
    if (res_tvalid === 1'b1 && res_tready === 1'b1) res_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_meas(input logic [W-1:0] m);
    int guard = 0;
    meas_tvalid = 1'b1;
    meas_tdata  = m;
    #1;
    while (meas_tready !== 1'b1 && guard < 50) begin
      tick;
      guard++;
    end
    n_checks++;
    if (meas_tready !== 1'b1) begin n_fail++; $display("FAIL meas_accept_wait: meas_tready=%b after %0d cycles, required 1", meas_tready, guard); end
    tick;
    meas_tvalid = 1'b0;
  endtask

  // Core model: ready low for two cycles, optional done pulses mid-wait and at ready-rise.
  task automatic run_core(input logic [W-1:0] m, input logic mid_done, input logic [W-1:0] mid_val,
                          input logic end_done, input logic [W-1:0] end_val);
    start_meas(m);
    tick;
    kf_ready = 1'b0;
    tick;
    kf_au_done = mid_done;
    kf_result  = mid_val;
    tick;
    kf_au_done = end_done;
    kf_result  = end_val;
    kf_ready   = 1'b1;
    tick;
    kf_au_done = 1'b0;
    kf_result  = '0;
  endtask

  task automatic drain;
    res_tready = 1'b1;
    tick;
    res_tready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    n_checks++;
    if ({loaded, busy, err, rom_we, kf_start, res_tvalid} !== 6'b0) begin n_fail++; $display("FAIL reset_flags: loaded/busy/err/rom_we/kf_start/res_tvalid=%b required 000000", {loaded, busy, err, rom_we, kf_start, res_tvalid}); end
    n_checks++;
    if (rom_waddr !== 8'h0 || rom_wdata !== 16'h0 || kf_data_in !== '0 || res_tdata !== '0) begin n_fail++; $display("FAIL reset_data: waddr=%h wdata=%h data_in=%h res=%h required all zero", rom_waddr, rom_wdata, kf_data_in, res_tdata); end
    n_checks++;
    if (prog_tready !== 1'b0 || meas_tready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: prog_tready=%b meas_tready=%b required 0 0", prog_tready, meas_tready); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_load;
    logic [15:0] w [3];
    w[0] = 16'hA001; w[1] = 16'hB002; w[2] = 16'hC003;
    load_req = 1'b1; prog_len = 9'd3;
    tick;
    load_req = 1'b0; prog_len = 9'd0;
    n_checks++;
    if (prog_tready !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL load_enter: prog_tready=%b busy=%b required 1 1", prog_tready, busy); end
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        prog_tvalid = 1'b0;
        tick;
        n_checks++;
        if (rom_we !== 1'b0) begin n_fail++; $display("FAIL load_stall_we: rom_we=%b required 0", rom_we); end
      end
      prog_tvalid = 1'b1; prog_tdata = w[i];
      tick;
      n_checks++;
      if (rom_we !== 1'b1 || rom_waddr !== 8'(i) || rom_wdata !== w[i]) begin n_fail++; $display("FAIL load_word%0d: we=%b addr=%h data=%h required 1 %h %h", i, rom_we, rom_waddr, rom_wdata, 8'(i), w[i]); end
      n_checks++;
      if (loaded !== (i == 2)) begin n_fail++; $display("FAIL load_loaded%0d: loaded=%b required %b", i, loaded, (i == 2)); end
    end
    prog_tvalid = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL load_run_state: busy=%b required 0", busy); end
    tick;
    n_checks++;
    if (rom_we !== 1'b0 || prog_tready !== 1'b0) begin n_fail++; $display("FAIL load_done: rom_we=%b prog_tready=%b required 0 0", rom_we, prog_tready); end
  endtask

  task automatic test_run;
    int s0 = start_cnt;
    int r0 = res_cnt;
    meas_tvalid = 1'b1; meas_tdata = 24'h000100;
    #1;
    n_checks++;
    if (meas_tready !== 1'b1) begin n_fail++; $display("FAIL run_meas_ready: meas_tready=%b required 1", meas_tready); end
    tick;
    meas_tvalid = 1'b0;
    n_checks++;
    if (kf_start !== 1'b1 || kf_data_in !== 24'h000100 || busy !== 1'b1) begin n_fail++; $display("FAIL run_start: kf_start=%b data_in=%h busy=%b required 1 000100 1", kf_start, kf_data_in, busy); end
    tick;
    n_checks++;
    if (kf_start !== 1'b0) begin n_fail++; $display("FAIL run_start_pulse: kf_start=%b required 0", kf_start); end
    tick;
    kf_ready = 1'b0;
    tick;
    kf_au_done = 1'b1; kf_result = 24'h000010;
    tick;
    kf_result = 24'h000020;
    tick;
    kf_au_done = 1'b0; kf_result = 24'hABCDEF;
    n_checks++;
    if (res_tvalid !== 1'b0) begin n_fail++; $display("FAIL run_early_res: res_tvalid=%b required 0", res_tvalid); end
    kf_ready = 1'b1;
    tick;
    n_checks++;
    if (res_tvalid !== 1'b1 || res_tdata !== 24'h000020) begin n_fail++; $display("FAIL run_result: res_tvalid=%b res_tdata=%h required 1 000020", res_tvalid, res_tdata); end
    n_checks++;
    if (busy !== 1'b0 || meas_tready !== 1'b0) begin n_fail++; $display("FAIL run_back_in_run: busy=%b meas_tready=%b required 0 0", busy, meas_tready); end
    kf_result = '0;
    drain;
    n_checks++;
    if (res_tvalid !== 1'b0) begin n_fail++; $display("FAIL run_drain: res_tvalid=%b required 0", res_tvalid); end
    n_checks++;
    if (start_cnt - s0 !== 1 || res_cnt - r0 !== 1) begin n_fail++; $display("FAIL run_counts: starts=%0d results=%0d required 1 1", start_cnt - s0, res_cnt - r0); end
  endtask

  task automatic test_capture;
    run_core(24'h000200, 1'b1, 24'h000077, 1'b1, 24'h000055);
    n_checks++;
    if (res_tvalid !== 1'b1 || res_tdata !== 24'h000055) begin n_fail++; $display("FAIL cap_coincident: res_tvalid=%b res_tdata=%h required 1 000055", res_tvalid, res_tdata); end
    drain;
    run_core(24'h000300, 1'b0, 24'h0, 1'b0, 24'h000099);
    n_checks++;
    if (res_tvalid !== 1'b1 || res_tdata !== 24'h000000) begin n_fail++; $display("FAIL cap_cleared: res_tvalid=%b res_tdata=%h required 1 000000", res_tvalid, res_tdata); end
    n_checks++;
    if (kf_data_in !== 24'h000300) begin n_fail++; $display("FAIL cap_data_in: kf_data_in=%h required 000300", kf_data_in); end
    drain;
  endtask

  task automatic test_backpressure;
    run_core(24'h000400, 1'b1, 24'h000123, 1'b0, 24'h0);
    meas_tvalid = 1'b1; meas_tdata = 24'h000500;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++;
      if (meas_tready !== 1'b0 || res_tvalid !== 1'b1 || res_tdata !== 24'h000123 || kf_data_in !== 24'h000400) begin
        n_fail++; $display("FAIL bp_hold%0d: meas_tready=%b res_tvalid=%b res=%h data_in=%h required 0 1 000123 000400", i, meas_tready, res_tvalid, res_tdata, kf_data_in);
      end
      tick;
    end
    drain;
    n_checks++;
    if (res_tvalid !== 1'b0 || meas_tready !== 1'b1) begin n_fail++; $display("FAIL bp_release: res_tvalid=%b meas_tready=%b required 0 1", res_tvalid, meas_tready); end
    tick;
    meas_tvalid = 1'b0;
    n_checks++;
    if (kf_start !== 1'b1 || kf_data_in !== 24'h000500) begin n_fail++; $display("FAIL bp_second_start: kf_start=%b data_in=%h required 1 000500", kf_start, kf_data_in); end
    kf_ready = 1'b0;
    tick;
    kf_ready = 1'b1;
    tick;
    n_checks++;
    if (res_tvalid !== 1'b1 || res_tdata !== 24'h000000) begin n_fail++; $display("FAIL bp_second_res: res_tvalid=%b res=%h required 1 000000", res_tvalid, res_tdata); end
    drain;
  endtask

  task automatic test_ignored;
    start_meas(24'h000042);
    kf_ready = 1'b0;
    tick;
    load_req = 1'b1; prog_len = 9'd3;
    tick;
    load_req = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || loaded !== 1'b1 || prog_tready !== 1'b0) begin n_fail++; $display("FAIL ign_wait_hi: busy=%b loaded=%b prog_tready=%b required 1 1 0", busy, loaded, prog_tready); end
    kf_ready = 1'b1;
    tick;
    n_checks++;
    if (res_tvalid !== 1'b1) begin n_fail++; $display("FAIL ign_run_completes: res_tvalid=%b required 1", res_tvalid); end
    drain;
    load_req = 1'b1; prog_len = 9'd0;
    tick;
    n_checks++;
    if (busy !== 1'b0 || loaded !== 1'b1 || prog_tready !== 1'b0) begin n_fail++; $display("FAIL ign_len0: busy=%b loaded=%b prog_tready=%b required 0 1 0", busy, loaded, prog_tready); end
    prog_len = 9'd257;
    tick;
    load_req = 1'b0; prog_len = 9'd0;
    n_checks++;
    if (busy !== 1'b0 || loaded !== 1'b1 || prog_tready !== 1'b0) begin n_fail++; $display("FAIL ign_len257: busy=%b loaded=%b prog_tready=%b required 0 1 0", busy, loaded, prog_tready); end
  endtask

  task automatic test_timeout;
    int r0 = res_cnt;
    start_meas(24'h000600);
    kf_ready = 1'b0;
`ifdef KF_DRV_TIMEOUT_EN
    repeat (TMO - 1) tick;
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL tmo_before: err=%b busy=%b required 0 1", err, busy); end
    tick;
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0 || res_tvalid !== 1'b0) begin n_fail++; $display("FAIL tmo_hit: err=%b busy=%b res_tvalid=%b required 1 0 0", err, busy, res_tvalid); end
    n_checks++;
    if (meas_tready !== 1'b0) begin n_fail++; $display("FAIL tmo_ready_low: meas_tready=%b required 0", meas_tready); end
    kf_ready = 1'b1;
    #1;
    n_checks++;
    if (meas_tready !== 1'b1) begin n_fail++; $display("FAIL tmo_ready_back: meas_tready=%b required 1", meas_tready); end
    tick;
    n_checks++;
    if (err !== 1'b1 || res_tvalid !== 1'b0 || res_cnt != r0) begin n_fail++; $display("FAIL tmo_sticky: err=%b res_tvalid=%b results=%0d required 1 0 0", err, res_tvalid, res_cnt - r0); end
`else
    repeat (3 * TMO) tick;
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b1 || res_tvalid !== 1'b0) begin n_fail++; $display("FAIL wait_forever: err=%b busy=%b res_tvalid=%b required 0 1 0", err, busy, res_tvalid); end
    kf_ready = 1'b1;
    tick;
    n_checks++;
    if (res_tvalid !== 1'b1 || res_tdata !== 24'h000000 || res_cnt != r0) begin n_fail++; $display("FAIL wait_late_res: res_tvalid=%b res=%h required 1 000000", res_tvalid, res_tdata); end
    drain;
`endif
  endtask

  task automatic test_reset_mid_load;
    load_req = 1'b1; prog_len = 9'd5;
    tick;
    load_req = 1'b0; prog_len = 9'd0;
    prog_tvalid = 1'b1; prog_tdata = 16'h1111;
    tick;
    prog_tdata = 16'h2222;
    tick;
    prog_tdata = 16'h3333;
    rst = 1'b1;
    tick;
    n_checks++;
    if ({loaded, busy, err, rom_we, kf_start, res_tvalid, prog_tready} !== 7'b0) begin n_fail++; $display("FAIL rst_mid_flags: loaded/busy/err/we/start/res_tvalid/prog_tready=%b required 0000000", {loaded, busy, err, rom_we, kf_start, res_tvalid, prog_tready}); end
    n_checks++;
    if (rom_waddr !== 8'h0 || rom_wdata !== 16'h0 || kf_data_in !== '0 || res_tdata !== '0) begin n_fail++; $display("FAIL rst_mid_data: waddr=%h wdata=%h data_in=%h res=%h required all zero", rom_waddr, rom_wdata, kf_data_in, res_tdata); end
    rst = 1'b0;
    tick;
    prog_tvalid = 1'b0;
    n_checks++;
    if (loaded !== 1'b0 || prog_tready !== 1'b0 || rom_we !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle: loaded=%b prog_tready=%b rom_we=%b busy=%b required 0 0 0 0", loaded, prog_tready, rom_we, busy); end
  endtask

  task automatic test_load_bounds;
    logic [15:0] d;
    load_req = 1'b1; prog_len = 9'd256;
    tick;
    load_req = 1'b0; prog_len = 9'd0;
    for (int i = 0; i < 256; i++) begin
      d = 16'(i * 7 + 16'h0100);
      prog_tvalid = 1'b1; prog_tdata = d;
      tick;
      n_checks++;
      if (rom_we !== 1'b1 || rom_waddr !== 8'(i) || rom_wdata !== d) begin n_fail++; $display("FAIL max_word%0d: we=%b addr=%h data=%h required 1 %h %h", i, rom_we, rom_waddr, rom_wdata, 8'(i), d); end
      if (i >= 254) begin
        n_checks++;
        if (loaded !== (i == 255)) begin n_fail++; $display("FAIL max_loaded%0d: loaded=%b required %b", i, loaded, (i == 255)); end
      end
    end
    prog_tvalid = 1'b0;
    tick;
    load_req = 1'b1; prog_len = 9'd1;
    tick;
    load_req = 1'b0; prog_len = 9'd0;
    n_checks++;
    if (loaded !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL reload_enter: loaded=%b busy=%b required 0 1", loaded, busy); end
    prog_tvalid = 1'b1; prog_tdata = 16'hD00D;
    tick;
    prog_tvalid = 1'b0;
    n_checks++;
    if (loaded !== 1'b1 || rom_waddr !== 8'h00 || rom_wdata !== 16'hD00D || busy !== 1'b0) begin n_fail++; $display("FAIL reload_len1: loaded=%b addr=%h data=%h busy=%b required 1 00 d00d 0", loaded, rom_waddr, rom_wdata, busy); end
    run_core(24'h000777, 1'b0, 24'h0, 1'b1, 24'h0ABCDE);
    n_checks++;
    if (res_tvalid !== 1'b1 || res_tdata !== 24'h0ABCDE) begin n_fail++; $display("FAIL reload_run: res_tvalid=%b res=%h required 1 0abcde", res_tvalid, res_tdata); end
    drain;
  endtask

  initial begin
    rst = 1'b1; load_req = 1'b0; prog_len = '0;
    prog_tvalid = 1'b0; prog_tdata = '0;
    meas_tvalid = 1'b0; meas_tdata = '0;
    res_tready = 1'b0;
    kf_ready = 1'b1; kf_result = '0; kf_au_done = 1'b0;
    test_reset;
    test_load;
    test_run;
    test_capture;
    test_backpressure;
    test_ignored;
    test_timeout;
    test_reset_mid_load;
    test_load_bounds;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
